titan_lsu: RTL and testbench

- Load/store unit directly downstream of the execute ALU. The ALU result is the effective address.
- Takes one memory request per instruction from the EX stage and runs a single-outstanding, ack-based data-bus transaction.
- Aligns and extends load data for writeback, and stalls the pipeline while the bus is busy.
- Flags misaligned accesses and bus faults to the trap logic.

---
 rtl/titan_lsu.sv | 164 ++++++++++++++++
 tb/tb_titan_lsu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/titan_lsu.sv
// titan_lsu: single-outstanding load/store unit sitting behind the EX-stage ALU.
// It accepts one memory op per instruction and drives an ack-based data bus.
// Bus outputs are registered at accept and held stable until ack or err.
// Load data is aligned and extended for writeback, and misaligned accesses and
// bus faults are reported to the trap logic as one-cycle pulses.
module titan_lsu #(
   parameter logic [31:0] RESET_ADDR_OUT = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [1:0]  ex_mem_size,
   input  logic        ex_mem_unsigned,
   input  logic        kill,
   output logic        lsu_stall,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   output logic [3:0]  dbus_sel,
   output logic        dbus_we,
   output logic        dbus_cyc,
   input  logic [31:0] dbus_rdata,
   input  logic        dbus_ack,
   input  logic        dbus_err,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic        exc_load_misaligned,
   output logic        exc_store_misaligned,
   output logic        exc_load_fault,
   output logic        exc_store_fault,
   output logic [31:0] exc_addr
);

   typedef enum logic {IDLE, REQ} state_t;

   // Attributes of the in-flight access, captured at accept.
   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic        ld;
   } req_t;

   state_t      state;
   req_t        cur;
   logic        killed;
   logic        req;
   logic        misaligned;
   logic [3:0]  sel_n;
   logic [31:0] wdata_n;
   logic [31:0] shifted;
   logic [31:0] ld_data;

   assign req        = ex_valid & (ex_mem_read | ex_mem_write) & ~kill;
   // Size 11 behaves as a word everywhere, so size[1] alone selects word.
   assign misaligned = ((ex_mem_size == 2'b01) & ex_addr[0]) |
                       (ex_mem_size[1] & (ex_addr[1:0] != 2'b00));
   assign lsu_stall  = (state == REQ) | ((state == IDLE) & req & ~misaligned);

   // Byte-lane enables and lane-replicated store data for the incoming request.
   always_comb begin
      sel_n   = 4'b1111;
      wdata_n = ex_wdata;
      case (ex_mem_size)
         2'b00: begin
            sel_n   = 4'b0001 << ex_addr[1:0];
            wdata_n = {4{ex_wdata[7:0]}};
         end
         2'b01: begin
            sel_n   = ex_addr[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{ex_wdata[15:0]}};
         end
         default: begin
            sel_n   = 4'b1111;
            wdata_n = ex_wdata;
         end
      endcase
   end

   // Shift the addressed lane down to bit 0, then sign- or zero-extend.
   always_comb begin
      shifted = dbus_rdata >> {cur.addr[1:0], 3'b000};
      ld_data = shifted;
      case (cur.size)
         2'b00:   ld_data = {{24{~cur.uns & shifted[7]}}, shifted[7:0]};
         2'b01:   ld_data = {{16{~cur.uns & shifted[15]}}, shifted[15:0]};
         default: ld_data = shifted;
      endcase
   end

   // Two-state request FSM with registered bus, writeback and trap outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                <= IDLE;
         cur                  <= '0;
         killed               <= 1'b0;
         dbus_cyc             <= 1'b0;
         dbus_we              <= 1'b0;
         dbus_sel             <= 4'b0000;
         dbus_wdata           <= 32'h0;
         dbus_addr            <= RESET_ADDR_OUT;
         wb_valid             <= 1'b0;
         wb_data              <= 32'h0;
         exc_load_misaligned  <= 1'b0;
         exc_store_misaligned <= 1'b0;
         exc_load_fault       <= 1'b0;
         exc_store_fault      <= 1'b0;
         exc_addr             <= RESET_ADDR_OUT;
      end else begin
         wb_valid             <= 1'b0;
         exc_load_misaligned  <= 1'b0;
         exc_store_misaligned <= 1'b0;
         exc_load_fault       <= 1'b0;
         exc_store_fault      <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  if (misaligned) begin
                     exc_load_misaligned  <= ex_mem_read;
                     exc_store_misaligned <= ~ex_mem_read;
                     exc_addr             <= ex_addr;
                  end else begin
                     state      <= REQ;
                     dbus_cyc   <= 1'b1;
                     dbus_we    <= ~ex_mem_read;
                     dbus_addr  <= {ex_addr[31:2], 2'b00};
                     dbus_sel   <= sel_n;
                     dbus_wdata <= wdata_n;
                     cur.addr   <= ex_addr;
                     cur.size   <= ex_mem_size;
                     cur.uns    <= ex_mem_unsigned;
                     cur.ld     <= ex_mem_read;
                     killed     <= 1'b0;
                  end
               end
            end
            REQ: begin
               if (kill) killed <= 1'b1;
               if (dbus_ack | dbus_err) begin
                  state    <= IDLE;
                  dbus_cyc <= 1'b0;
                  dbus_we  <= 1'b0;
                  // A flush seen in any REQ cycle, including this one, drops the result.
                  if (!(killed | kill)) begin
                     if (dbus_err) begin
                        exc_load_fault  <= cur.ld;
                        exc_store_fault <= ~cur.ld;
                        exc_addr        <= cur.addr;
                     end else if (cur.ld) begin
                        wb_valid <= 1'b1;
                        wb_data  <= ld_data;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_titan_lsu.sv
// Directed bench for titan_lsu: a table of single transactions with
// hand-computed bus and writeback values, plus hand-written sequences for
// reset, kill, back-to-back issue and non-memory instructions.
module tb_titan_lsu;

   localparam logic [31:0] RST_ADDR = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_mem_read, ex_mem_write, ex_mem_unsigned, kill;
   logic [31:0] ex_addr, ex_wdata, dbus_rdata;
   logic [1:0]  ex_mem_size;
   logic        dbus_ack, dbus_err;
   logic        lsu_stall, dbus_we, dbus_cyc, wb_valid;
   logic [31:0] dbus_addr, dbus_wdata, wb_data, exc_addr;
   logic [3:0]  dbus_sel;
   logic        exc_load_misaligned, exc_store_misaligned, exc_load_fault, exc_store_fault;

   int passed = 0;
   int total  = 0;

   titan_lsu #(.RESET_ADDR_OUT(RST_ADDR)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_addr(ex_addr),
      .ex_wdata(ex_wdata), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned), .kill(kill),
      .lsu_stall(lsu_stall), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
      .dbus_sel(dbus_sel), .dbus_we(dbus_we), .dbus_cyc(dbus_cyc),
      .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack), .dbus_err(dbus_err),
      .wb_valid(wb_valid), .wb_data(wb_data),
      .exc_load_misaligned(exc_load_misaligned), .exc_store_misaligned(exc_store_misaligned),
      .exc_load_fault(exc_load_fault), .exc_store_fault(exc_store_fault),
      .exc_addr(exc_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rd;
      logic        wr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] rdata;
      int          waits;
      logic        err;
      logic [31:0] e_addr;
      logic [3:0]  e_sel;
      logic [31:0] e_wdata;
      logic        e_we;
      int          e_stall;
      logic        e_wb;
      logic [31:0] e_wbdata;
      logic [3:0]  e_exc;   // {load_mis, store_mis, load_fault, store_fault}
      logic [31:0] e_excaddr;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   function automatic logic [3:0] exc_vec();
      return {exc_load_misaligned, exc_store_misaligned, exc_load_fault, exc_store_fault};
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                        input logic wr, input logic [1:0] sz, input logic un);
      ex_valid = 1'b1; ex_addr = a; ex_wdata = wd; ex_mem_read = rd;
      ex_mem_write = wr; ex_mem_size = sz; ex_mem_unsigned = un;
   endtask

   task automatic idle_inputs();
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      dbus_ack = 1'b0; dbus_err = 1'b0; kill = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int stalls;
      logic mis;
      mis = (v.e_exc[3:2] != 2'b00);
      @(negedge clk);
      drive(v.addr, v.wdata, v.rd, v.wr, v.size, v.uns);
      #1 chk({v.name, " stall_at_accept"}, {31'b0, lsu_stall}, {31'b0, ~mis});
      if (mis) begin
         @(negedge clk);
         chk({v.name, " exc"}, {28'b0, exc_vec()}, {28'b0, v.e_exc});
         chk({v.name, " exc_addr"}, exc_addr, v.e_excaddr);
         chk({v.name, " no_cyc"}, {31'b0, dbus_cyc}, 32'h0);
         idle_inputs();
      end else begin
         stalls = 1;
         @(negedge clk);
         chk({v.name, " cyc"}, {31'b0, dbus_cyc}, 32'h1);
         chk({v.name, " addr"}, dbus_addr, v.e_addr);
         chk({v.name, " sel"}, {28'b0, dbus_sel}, {28'b0, v.e_sel});
         chk({v.name, " wdata"}, dbus_wdata, v.e_wdata);
         chk({v.name, " we"}, {31'b0, dbus_we}, {31'b0, v.e_we});
         for (int i = 0; i < v.waits; i++) begin
            stalls += int'(lsu_stall);
            @(negedge clk);
         end
         stalls += int'(lsu_stall);
         dbus_ack = 1'b1; dbus_err = v.err; dbus_rdata = v.rdata;
         @(negedge clk);
         idle_inputs();
         chk({v.name, " cyc_dropped"}, {31'b0, dbus_cyc}, 32'h0);
         chk({v.name, " stall_cycles"}, stalls, v.e_stall);
         chk({v.name, " wb_valid"}, {31'b0, wb_valid}, {31'b0, v.e_wb});
         if (v.e_wb) chk({v.name, " wb_data"}, wb_data, v.e_wbdata);
         chk({v.name, " exc"}, {28'b0, exc_vec()}, {28'b0, v.e_exc});
         if (v.e_exc != 4'b0) chk({v.name, " exc_addr"}, exc_addr, v.e_excaddr);
      end
      @(negedge clk);
      chk({v.name, " pulses_clear"}, {27'b0, wb_valid, exc_vec()}, 32'h0);
   endtask

   initial begin
      //        name     addr          wdata         rd   wr   sz     un   rdata         w  err  e_addr        e_sel    e_wdata       we   st wb   wbdata        exc      excaddr
      vecs[0]  = '{"LW",   32'h0000_1004, 32'h0,        1'b1,1'b0,2'b10,1'b0,32'hDEAD_BEEF,1,1'b0,32'h0000_1004,4'b1111,32'h0,        1'b0,3,1'b1,32'hDEAD_BEEF,4'b0000,32'h0};
      vecs[1]  = '{"LB",   32'h0000_2003, 32'h0,        1'b1,1'b0,2'b00,1'b0,32'h80FF_FFFF,0,1'b0,32'h0000_2000,4'b1000,32'h0,        1'b0,2,1'b1,32'hFFFF_FF80,4'b0000,32'h0};
      vecs[2]  = '{"LBU",  32'h0000_2003, 32'h0,        1'b1,1'b0,2'b00,1'b1,32'h80FF_FFFF,0,1'b0,32'h0000_2000,4'b1000,32'h0,        1'b0,2,1'b1,32'h0000_0080,4'b0000,32'h0};
      vecs[3]  = '{"SH",   32'h0000_3002, 32'h1234_ABCD,1'b0,1'b1,2'b01,1'b0,32'h0,        0,1'b0,32'h0000_3000,4'b1100,32'hABCD_ABCD,1'b1,2,1'b0,32'h0,        4'b0000,32'h0};
      vecs[4]  = '{"LWmis",32'h0000_4002, 32'h0,        1'b1,1'b0,2'b10,1'b0,32'h0,        0,1'b0,32'h0,        4'b0000,32'h0,        1'b0,0,1'b0,32'h0,        4'b1000,32'h0000_4002};
      vecs[5]  = '{"SWerr",32'h0000_5000, 32'hCAFE_F00D,1'b0,1'b1,2'b10,1'b0,32'h0,        0,1'b1,32'h0000_5000,4'b1111,32'hCAFE_F00D,1'b1,2,1'b0,32'h0,        4'b0001,32'h0000_5000};
      vecs[6]  = '{"LH",   32'h0000_6002, 32'h0,        1'b1,1'b0,2'b01,1'b0,32'h8001_1234,2,1'b0,32'h0000_6000,4'b1100,32'h0,        1'b0,4,1'b1,32'hFFFF_8001,4'b0000,32'h0};
      vecs[7]  = '{"LHU",  32'h0000_6000, 32'h0,        1'b1,1'b0,2'b01,1'b1,32'h8001_F234,0,1'b0,32'h0000_6000,4'b0011,32'h0,        1'b0,2,1'b1,32'h0000_F234,4'b0000,32'h0};
      vecs[8]  = '{"SB",   32'h0000_7001, 32'h0000_00A5,1'b0,1'b1,2'b00,1'b0,32'h0,        1,1'b0,32'h0000_7000,4'b0010,32'hA5A5_A5A5,1'b1,3,1'b0,32'h0,        4'b0000,32'h0};
      vecs[9]  = '{"SHmis",32'h0000_7001, 32'h0000_1111,1'b0,1'b1,2'b01,1'b0,32'h0,        0,1'b0,32'h0,        4'b0000,32'h0,        1'b0,0,1'b0,32'h0,        4'b0100,32'h0000_7001};
      vecs[10] = '{"LWsz3",32'h0000_8000, 32'h0,        1'b1,1'b0,2'b11,1'b0,32'h1122_3344,0,1'b0,32'h0000_8000,4'b1111,32'h0,        1'b0,2,1'b1,32'h1122_3344,4'b0000,32'h0};
      vecs[11] = '{"LBrw", 32'h0000_9001, 32'h0,        1'b1,1'b1,2'b00,1'b0,32'h0000_7F00,0,1'b0,32'h0000_9000,4'b0010,32'h0,        1'b0,2,1'b1,32'h0000_007F,4'b0000,32'h0};
      vecs[12] = '{"LWerr",32'h0000_A008, 32'h0,        1'b1,1'b0,2'b10,1'b0,32'h0,        1,1'b1,32'h0000_A008,4'b1111,32'h0,        1'b0,3,1'b0,32'h0,        4'b0010,32'h0000_A008};

      idle_inputs();
      ex_addr = 32'h0; ex_wdata = 32'h0; ex_mem_size = 2'b00; ex_mem_unsigned = 1'b0;
      dbus_rdata = 32'h0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst cyc/we/wb/stall", {28'b0, dbus_cyc, dbus_we, wb_valid, lsu_stall}, 32'h0);
      chk("rst exc", {28'b0, exc_vec()}, 32'h0);
      chk("rst sel", {28'b0, dbus_sel}, 32'h0);
      chk("rst wdata", dbus_wdata, 32'h0);
      chk("rst wb_data", wb_data, 32'h0);
      chk("rst dbus_addr", dbus_addr, RST_ADDR);
      chk("rst exc_addr", exc_addr, RST_ADDR);
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Non-memory instruction: no stall, no bus cycle.
      @(negedge clk);
      drive(32'h0000_1000, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0);
      #1 chk("nonmem stall", {31'b0, lsu_stall}, 32'h0);
      @(negedge clk);
      chk("nonmem cyc", {30'b0, dbus_cyc, wb_valid}, 32'h0);
      idle_inputs();

      // Kill in IDLE suppresses an aligned accept and a misaligned pulse.
      @(negedge clk);
      drive(32'h0000_C000, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0); kill = 1'b1;
      #1 chk("idle kill stall", {31'b0, lsu_stall}, 32'h0);
      @(negedge clk);
      chk("idle kill cyc", {31'b0, dbus_cyc}, 32'h0);
      drive(32'h0000_C001, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      @(negedge clk);
      chk("idle kill mis", {28'b0, exc_vec()}, 32'h0);
      idle_inputs();

      // Kill in first REQ cycle: bus runs to ack, writeback suppressed.
      @(negedge clk);
      drive(32'h0000_B000, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill cyc held1", {31'b0, dbus_cyc}, 32'h1);
      @(negedge clk);
      chk("kill cyc held2", {31'b0, dbus_cyc}, 32'h1);
      dbus_ack = 1'b1; dbus_rdata = 32'h5555_AAAA;
      @(negedge clk);
      idle_inputs();
      chk("kill cyc drop", {31'b0, dbus_cyc}, 32'h0);
      chk("kill no wb", {31'b0, wb_valid}, 32'h0);

      // Back-to-back: second load accepted in the cycle wb_valid pulses.
      @(negedge clk);
      drive(32'h0000_D000, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      @(negedge clk);
      dbus_ack = 1'b1; dbus_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      dbus_ack = 1'b0;
      drive(32'h0000_D100, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      chk("b2b wb first", {31'b0, wb_valid}, 32'h1);
      chk("b2b wb data", wb_data, 32'h0BAD_F00D);
      #1 chk("b2b stall", {31'b0, lsu_stall}, 32'h1);
      @(negedge clk);
      chk("b2b cyc", {31'b0, dbus_cyc}, 32'h1);
      chk("b2b addr", dbus_addr, 32'h0000_D100);
      dbus_ack = 1'b1; dbus_rdata = 32'h1357_9BDF;
      @(negedge clk);
      idle_inputs();
      chk("b2b wb second", wb_data, 32'h1357_9BDF);

      // Reset mid-REQ drops dbus_cyc at once; a later ack does nothing.
      @(negedge clk);
      drive(32'h0000_E000, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      @(negedge clk);
      chk("rstreq cyc before", {31'b0, dbus_cyc}, 32'h1);
      rst_n = 1'b0;
      #1 chk("rstreq cyc async", {31'b0, dbus_cyc}, 32'h0);
      chk("rstreq addr", dbus_addr, RST_ADDR);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      dbus_ack = 1'b0;
      chk("rstreq late ack", {30'b0, dbus_cyc, wb_valid}, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
